online_otf_converter: RTL and testbench
=======================================

// Module: online_otf_converter
// PURPOSE
//  Converts one redundant signed-digit (borrow-save) word from the online datapath
//  (online adders, constant-coefficient multipliers) into a conventional two's-complement integer.
//  Uses MSB-first on-the-fly conversion, one digit per clock.
//  Sits at the output of an online arithmetic chain, ahead of conventional logic and result capture.
// PARAMETERS
//  Stage  10  number of signed digits per input word (input width 2*Stage)
// PORTS
//  clk        in   1          single clock, rising edge
//  rst        in   1          synchronous, active-high reset
//  in_valid   in   1          x holds a word to convert
//  in_ready   out  1          converter can accept a word
//  x          in   2*Stage    redundant word, digit 0 (MSB) in bits [2*Stage-1:2*Stage-2]
//  out_valid  out  1          y holds a finished result
//  out_ready  in   1          consumer accepts y
//  y          out  Stage+1    two's-complement value of x
//  busy       out  1          conversion in progress
// BEHAVIOUR
//  - Digit encoding: pair {p,n}; value = p - n.
//    10=+1, 01=-1, 00=0, 11=0 (11 accepted, treated as zero).
//  - Word value = sum d_i*2^(Stage-1-i), i=0..Stage-1.
//    Range +/-(2^Stage-1), so Stage+1 result bits never overflow.
//  - FSM states IDLE, CONV, DONE.
//    - IDLE: in_ready=1. On in_valid&in_ready:
//      - latch x into shift register;
//      - set Q=0 and QM=all ones (-1);
//      - set digit counter=0;
//      - go to CONV.
//    - CONV: each cycle consume the top digit and shift the register left by 2.
//      - d=+1: Q<={Q,1},  QM<={Q,0}
//      - d= 0: Q<={Q,0},  QM<={QM,1}
//      - d=-1: Q<={QM,1}, QM<={QM,0}
//      - Registers are Stage+1 wide and shift left, discarding the MSB.
//      - After the Stage-th digit, go to DONE.
//    - DONE: out_valid=1 and y=Q, held stable until out_ready.
//      - On out_valid&out_ready, go to IDLE.
//      - A word is not accepted in the same cycle it is handed out.
//  - Latency: input accepted at edge T; out_valid=1 after edge T+Stage.
//    Throughput: one word per Stage+2 cycles with out_ready tied high.
//  - in_ready=0 in CONV and DONE; x is ignored there.
//  - y changes only on entry to DONE. It holds its last value in IDLE and CONV.
//  - busy=1 exactly in CONV.
//  - Reset, including mid-CONV or in DONE with out_ready=0:
//    - state=IDLE, in_ready=1, out_valid=0, busy=0;
//    - y=0, Q=0, QM=all ones, counter=0;
//    - any partial word is discarded.
//  - in_valid during reset is ignored; acceptance happens on the first edge after rst falls.
// STRUCTURE
//  - Shared package (online_pkg):
//    - digit constants DIG_POS=2'b10, DIG_NEG=2'b01, DIG_ZERO=2'b00;
//    - FSM state encoding (IDLE/CONV/DONE);
//    - width helper WL_DIG(n)=2*n.
//  - One sub-module: online_otf_step, a combinational Q/QM update for one digit, parameterised by width.
//    The top level holds the FSM, digit shift register, counter and output register.
// TESTING  (Stage=4, y 5 bits, out_ready=1 unless stated)
//  1. x=8'b10000000 (+1,0,0,0) -> after 4 cycles y=5'b01000 (+8), out_valid 1 cycle.
//  2. x=8'b10010101 (+1,-1,-1,-1) -> y=5'b00001 (+1).
//     x=8'b01000000 -> y=5'b11000 (-8).
//  3. x=8'b10101010 -> y=5'b01111 (+15).
//     x=8'b01010101 -> y=5'b10001 (-15).
//     x=8'b11111111 -> y=5'b00000.
//  4. Backpressure: out_ready=0 for 6 cycles after out_valid.
//     -> y and out_valid held, in_ready=0, new x ignored.
//     out_ready=1 -> IDLE next cycle.
//  5. rst pulsed in the 2nd CONV cycle.
//     -> next cycle out_valid=0, busy=0, in_ready=1, y=0.
//     Following word x=8'b00100000 -> y=5'b00100.
//  6. Random back-to-back words, random out_ready.
//     -> y equals the signed sum of digits for every word, with no word lost or duplicated.

Source files
------------

// File: rtl/online_pkg.sv
// rtl/online_pkg.sv - shared digit constants, FSM encoding and width helper for online conversion
package online_pkg;

  // Borrow-save digit pairs {p,n}; 2'b11 is also legal and means zero
  localparam logic [1:0] DIG_POS  = 2'b10;
  localparam logic [1:0] DIG_NEG  = 2'b01;
  localparam logic [1:0] DIG_ZERO = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } otf_state_t;

  // Bit width of a word carrying n signed digits
  function automatic int WL_DIG(input int n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/online_otf_step.sv
// rtl/online_otf_step.sv - one on-the-fly conversion step: Q/QM update for a single signed digit
module online_otf_step
  import online_pkg::*;
#(
  parameter int W = 11
) (
  input  logic [1:0]   d,
  input  logic [W-1:0] q,
  input  logic [W-1:0] qm,
  output logic [W-1:0] q_next,
  output logic [W-1:0] qm_next
);

  // Append the digit to Q (value so far) and QM (value so far minus one ulp);
  // the left shift drops the MSB, which cannot matter since the result never overflows W bits
  always_comb begin
    q_next  = {q[W-2:0], 1'b0};
    qm_next = {qm[W-2:0], 1'b1};
    case (d)
      DIG_POS: begin
        q_next  = {q[W-2:0], 1'b1};
        qm_next = {q[W-2:0], 1'b0};
      end
      DIG_NEG: begin
        q_next  = {qm[W-2:0], 1'b1};
        qm_next = {qm[W-2:0], 1'b0};
      end
      default: begin
        // zero digit, including the redundant 2'b11 encoding
        q_next  = {q[W-2:0], 1'b0};
        qm_next = {qm[W-2:0], 1'b1};
      end
    endcase
  end

endmodule

// File: rtl/online_otf_converter.sv
// rtl/online_otf_converter.sv - MSB-first borrow-save to two's-complement converter, one digit per clock
module online_otf_converter
  import online_pkg::*;
#(
  parameter int Stage = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*Stage-1:0]    x,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [Stage:0]        y,
  output logic                  busy
);

  localparam int XW = WL_DIG(Stage);
  localparam int RW = Stage + 1;
  localparam int CW = $clog2(Stage + 1);
  localparam logic [CW-1:0] LAST_DIG = CW'(Stage - 1);

  otf_state_t      state;
  otf_state_t      state_next;
  logic [XW-1:0]   shreg;
  logic [CW-1:0]   cnt;
  logic [RW-1:0]   q;
  logic [RW-1:0]   qm;
  logic [RW-1:0]   q_step;
  logic [RW-1:0]   qm_step;
  logic            last_digit;

  assign last_digit = (cnt == LAST_DIG);

  online_otf_step #(.W(RW)) u_step (
    .d       (shreg[XW-1:XW-2]),
    .q       (q),
    .qm      (qm),
    .q_next  (q_step),
    .qm_next (qm_step)
  );

  // Next-state and handshake outputs; DONE never accepts, so a word is not taken while one is handed out
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ST_CONV;
      end
      ST_CONV: begin
        busy = 1'b1;
        if (last_digit) state_next = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Datapath: load on accept, consume one digit per CONV cycle, capture y only on entry to DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
      q     <= '0;
      qm    <= '1;
      y     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            shreg <= x;
            cnt   <= '0;
            q     <= '0;
            qm    <= '1;
          end
        end
        ST_CONV: begin
          shreg <= {shreg[XW-3:0], 2'b00};
          q     <= q_step;
          qm    <= qm_step;
          cnt   <= cnt + 1'b1;
          if (last_digit) y <= q_step;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_online_otf_converter.sv
// tb/tb_online_otf_converter.sv - randomized and directed self-checking bench for online_otf_converter
module tb_online_otf_converter;

  localparam int Stage = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2*Stage-1:0] x;
  logic             out_valid;
  logic             out_ready;
  logic [Stage:0]   y;
  logic             busy;

  int checks = 0;
  int errors = 0;

  online_otf_converter #(.Stage(Stage)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: signed sum of digits weighted by powers of two, wrapped to Stage+1 bits
  function automatic logic [Stage:0] ref_value(input logic [2*Stage-1:0] w);
    int v;
    int p;
    int n;
    logic [31:0] vb;
    v = 0;
    for (int i = 0; i < Stage; i++) begin
      p = int'(w[2*Stage-1-2*i]);
      n = int'(w[2*Stage-2-2*i]);
      v += (p - n) * (1 << (Stage - 1 - i));
    end
    vb = v;
    return vb[Stage:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a word in IDLE, then wait for out_valid; returns edges from acceptance to out_valid
  task automatic convert(input logic [2*Stage-1:0] w, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    check("in_ready_before_send", in_ready, 1);
    in_valid = 1'b1;
    x = w;
    tick();
    in_valid = 1'b0;
    check("busy_after_accept", busy, 1);
    lat = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
  endtask

  int lat;
  logic [Stage:0] q_exp[$];
  logic [Stage:0] ycap;
  logic [Stage:0] e;
  logic [2*Stage-1:0] xcap;
  logic acc;
  logic del;
  int n_acc;
  int n_del;
  int guard;

  initial begin
    rst = 1'b1;
    in_valid = 1'b1;
    x = 8'b10101010;
    out_ready = 1'b1;
    tick();
    tick();
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_y", y, 0);
    rst = 1'b0;
    in_valid = 1'b0;
    tick();

    // Test 1: latency, value, single-cycle out_valid
    convert(8'b10000000, lat);
    check("t1_latency", lat, Stage);
    check("t1_y", y, 5'b01000);
    tick();
    check("t1_out_valid_one_cycle", out_valid, 0);
    check("t1_back_idle", in_ready, 1);

    // Tests 2 and 3: directed values from the reference model and fixed constants
    begin
      logic [2*Stage-1:0] dirs [5];
      logic [Stage:0]     exps [5];
      dirs = '{8'b10010101, 8'b01000000, 8'b10101010, 8'b01010101, 8'b11111111};
      exps = '{5'b00001, 5'b11000, 5'b01111, 5'b10001, 5'b00000};
      for (int i = 0; i < 5; i++) begin
        convert(dirs[i], lat);
        check($sformatf("dir%0d_latency", i), lat, Stage);
        check($sformatf("dir%0d_y", i), y, exps[i]);
        check($sformatf("dir%0d_model", i), y, ref_value(dirs[i]));
        tick();
      end
    end

    // Test 4: backpressure holds y and out_valid, ignores new x
    out_ready = 1'b0;
    convert(8'b10100000, lat);
    check("t4_y", y, 5'b01100);
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      x = 8'($urandom);
      tick();
      check("t4_hold_out_valid", out_valid, 1);
      check("t4_hold_y", y, 5'b01100);
      check("t4_in_ready_low", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("t4_release_idle", in_ready, 1);
    check("t4_release_out_valid", out_valid, 0);

    // Test 5: reset in the second CONV cycle discards the word and clears y
    in_valid = 1'b1;
    x = 8'b10101010;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_out_valid", out_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_in_ready", in_ready, 1);
    check("t5_y", y, 0);
    convert(8'b00100000, lat);
    check("t5_latency", lat, Stage);
    check("t5_y_after", y, 5'b00100);
    tick();

    // Test 6: random traffic against a scoreboard queue
    n_acc = 0;
    n_del = 0;
    for (int c = 0; c < 3000; c++) begin
      in_valid  = 1'($urandom);
      x         = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      acc  = in_valid && in_ready;
      del  = out_valid && out_ready;
      ycap = y;
      xcap = x;
      tick();
      if (acc) begin
        q_exp.push_back(ref_value(xcap));
        n_acc++;
      end
      if (del) begin
        n_del++;
        if (q_exp.size() == 0) check("t6_unexpected_output", 1, 0);
        else begin
          e = q_exp.pop_front();
          check("t6_y", ycap, e);
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (q_exp.size() != 0 && guard < 200) begin
      del  = out_valid && out_ready;
      ycap = y;
      tick();
      guard++;
      if (del) begin
        n_del++;
        e = q_exp.pop_front();
        check("t6_drain_y", ycap, e);
      end
    end
    check("t6_queue_empty", q_exp.size(), 0);
    check("t6_count_match", n_del, n_acc);
    check("t6_some_traffic", (n_acc > 100), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
